// File: rtl/can_modport.sv
// CAN node front end: multiplexed 8-bit host register file, one-byte MSB-first transmitter, rx activity flag.
// Host reads are combinational, writes take one edge; tx_o shows bit7 the cycle after an accepted request; no backpressure.
module can_modport (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ale_i,
    input  logic       rd_i,
    input  logic       wr_i,
    input  logic       cs_can_i,
    inout  wire  [7:0] port_0_io,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       irq_on,
    output logic       bus_off_on,
    output logic       clk_out_o
);

    typedef enum logic {IDLE, SHIFT} tx_state_t;

    tx_state_t  state, state_nxt;
    logic [7:0] addr;
    logic       wr_q;
    logic       reset_mode, listen_only;
    logic [7:0] ier;
    logic [5:0] brp;
    logic [7:0] txbuf, txerr;
    logic [2:0] cd;
    logic       clkoff;
    logic       ir_rx, ir_tx, ir_bo;
    logic       tx_complete;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [6:0] tq_cnt;
    logic [2:0] clk_cnt;
    logic       rx_s1, rx_s2, rx_q;
    logic       bus_off_q;
    logic       ir_rd_pend;
    logic [7:0] rd_dat;

    logic       wr_stb, rd_en, bus_off, tx_busy, ir_clr, rx_fall, bo_rise;
    logic       tx_req, abort, bit_end, load, shift, done;
    logic [7:0] bus_dat;
    logic [7:0] ir_vec;

    assign bus_dat  = port_0_io;
    assign wr_stb   = wr_i & cs_can_i & ~wr_q;
    assign rd_en    = cs_can_i & rd_i & ~wr_i;
    assign bus_off  = (txerr == 8'hFF);
    assign tx_busy  = (state == SHIFT);
    assign ir_clr   = ir_rd_pend & ~rd_i;
    assign rx_fall  = rx_q & ~rx_s2 & ~reset_mode;
    assign bo_rise  = bus_off & ~bus_off_q;
    assign ir_vec   = {ir_bo, 5'b0, ir_tx, ir_rx};

    assign port_0_io = rd_en ? rd_dat : 8'hzz;

    // Request sees the mode bits as they stand before this edge; abort also catches a MODE write landing now.
    assign tx_req  = wr_stb & (addr == 8'd1) & bus_dat[0] & ~reset_mode & ~listen_only;
    assign abort   = reset_mode | (wr_stb & (addr == 8'd0) & bus_dat[0]);
    assign bit_end = (tq_cnt == {brp, 1'b1});

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_req) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_o = tx_busy ? shreg[7] : 1'b1;

    always_comb begin
        rd_dat = 8'h00;
        case (addr)
            8'd0:  rd_dat = {6'b0, listen_only, reset_mode};
            8'd1:  rd_dat = 8'hFF;
            8'd2:  rd_dat = {bus_off, 1'b0, tx_busy, 1'b0, tx_complete, ~tx_busy, 2'b0};
            8'd3:  rd_dat = ir_vec;
            8'd4:  rd_dat = ier;
            8'd6:  rd_dat = {2'b0, brp};
            8'd10: rd_dat = txbuf;
            8'd14: rd_dat = txerr;
            8'd31: rd_dat = {4'b0, clkoff, cd};
            default: rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr        <= 8'h00;
            wr_q        <= 1'b0;
            reset_mode  <= 1'b1;
            listen_only <= 1'b0;
            ier         <= 8'h00;
            brp         <= 6'h00;
            txbuf       <= 8'h00;
            txerr       <= 8'h00;
            cd          <= 3'h0;
            clkoff      <= 1'b0;
        end else begin
            wr_q <= wr_i;
            if (ale_i) begin
                addr <= bus_dat;
            end
            if (wr_stb) begin
                case (addr)
                    8'd0:  {listen_only, reset_mode} <= bus_dat[1:0];
                    8'd4:  ier <= bus_dat & 8'h83;
                    8'd6:  if (reset_mode) brp <= bus_dat[5:0];
                    8'd10: txbuf <= bus_dat;
                    8'd14: if (reset_mode) txerr <= bus_dat;
                    8'd31: {clkoff, cd} <= bus_dat[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            shreg       <= 8'h00;
            bit_cnt     <= 3'd0;
            tq_cnt      <= 7'd0;
            tx_complete <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shreg       <= txbuf;
                bit_cnt     <= 3'd0;
                tx_complete <= 1'b0;
            end else if (shift) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (done) begin
                tx_complete <= 1'b1;
            end
            if (state_nxt != SHIFT || load || bit_end) begin
                tq_cnt <= 7'd0;
            end else begin
                tq_cnt <= tq_cnt + 7'd1;
            end
        end
    end

    // Interrupt flags: a set event in the read-clear cycle takes priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_q       <= 1'b1;
            bus_off_q  <= 1'b0;
            ir_rd_pend <= 1'b0;
            ir_rx      <= 1'b0;
            ir_tx      <= 1'b0;
            ir_bo      <= 1'b0;
            irq_on     <= 1'b1;
            bus_off_on <= 1'b1;
        end else begin
            rx_s1     <= rx_i;
            rx_s2     <= rx_s1;
            rx_q      <= rx_s2;
            bus_off_q <= bus_off;
            if (cs_can_i & rd_i & (addr == 8'd3)) begin
                ir_rd_pend <= 1'b1;
            end else if (!rd_i) begin
                ir_rd_pend <= 1'b0;
            end
            ir_rx      <= rx_fall | (ir_rx & ~ir_clr);
            ir_tx      <= done    | (ir_tx & ~ir_clr);
            ir_bo      <= bo_rise | (ir_bo & ~ir_clr);
            irq_on     <= ~|(ir_vec & ier);
            bus_off_on <= ~bus_off;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_cnt   <= 3'd0;
            clk_out_o <= 1'b0;
        end else if (clkoff) begin
            clk_cnt   <= 3'd0;
            clk_out_o <= 1'b0;
        end else if (clk_cnt == cd) begin
            clk_cnt   <= 3'd0;
            clk_out_o <= ~clk_out_o;
        end else begin
            clk_cnt <= clk_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_can_modport.sv
// Directed bench for can_modport with a register/transmit-waveform model checked every cycle.
module tb_can_modport;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ale = 1'b0, rd = 1'b0, wr = 1'b0, cs = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    wire  [7:0] port_0_io;
    logic       tx_o, irq_on, bus_off_on, clk_out_o;

    assign port_0_io = drv_en ? drv : 8'hzz;

    can_modport dut (
        .clk_i(clk), .rst_i(rst), .ale_i(ale), .rd_i(rd), .wr_i(wr),
        .cs_can_i(cs), .port_0_io(port_0_io), .rx_i(rx), .tx_o(tx_o),
        .irq_on(irq_on), .bus_off_on(bus_off_on), .clk_out_o(clk_out_o)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Behavioural model: register shadows plus the expected transmit waveform as a function of time.
    logic [7:0] m_mode, m_btr, m_txbuf, m_txerr, m_ier, m_cdr, m_byte;
    bit         m_on = 0, m_tx_on = 0;
    int         m_t0 = 0, m_per = 2;

    function automatic logic model_tx();
        int k;
        k = cyc - m_t0;
        if (m_tx_on && k >= 0 && k < 8 * m_per) return m_byte[7 - k / m_per];
        return 1'b1;
    endfunction

    function automatic bit model_busy();
        return m_tx_on && (cyc - m_t0) < 8 * m_per;
    endfunction

    task automatic model_reset();
        m_mode = 8'h01; m_btr = 8'h00; m_txbuf = 8'h00; m_txerr = 8'h00;
        m_ier = 8'h00; m_cdr = 8'h00; m_tx_on = 0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        case (a)
            8'd0: begin
                m_mode = d & 8'h03;
                if (d[0]) m_tx_on = 0;
            end
            8'd1: if (d[0] && !model_busy() && m_mode == 8'h00) begin
                m_tx_on = 1; m_t0 = cyc; m_byte = m_txbuf; m_per = 2 * (int'(m_btr) + 1);
            end
            8'd4:  m_ier = d & 8'h83;
            8'd6:  if (m_mode[0]) m_btr = d & 8'h3F;
            8'd10: m_txbuf = d;
            8'd14: if (m_mode[0]) m_txerr = d;
            8'd31: m_cdr = d & 8'h0F;
            default: ;
        endcase
    endtask

    always begin
        @(negedge clk);
        #1;
        if (m_on) begin
            total++;
            if (tx_o !== model_tx()) begin
                bad++;
                $display("FAIL tx_model cyc=%0d act=%b exp=%b", cyc, tx_o, model_tx());
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); drv = a; drv_en = 1; ale = 1;
        @(negedge clk); ale = 0; drv = d; cs = 1; wr = 1;
        @(negedge clk); wr = 0; cs = 0; drv_en = 0;
        model_write(a, d);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk); drv = a; drv_en = 1; ale = 1;
        @(negedge clk); ale = 0; drv_en = 0; cs = 1; rd = 1;
        #1 d = port_0_io;
        @(negedge clk); rd = 0; cs = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_rise(output int t, output bit ok);
        logic p;
        p = clk_out_o; ok = 0; t = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (clk_out_o && !p) begin ok = 1; t = cyc; end
            p = clk_out_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic [7:0] pat;
        int t1, t2;
        bit ok1, ok2, seen;
        int n;

        // T1 reset
        model_reset();
        #23;
        chk("rst_tx", 8'(tx_o), 8'h01);
        chk("rst_irq", 8'(irq_on), 8'h01);
        chk("rst_busoff", 8'(bus_off_on), 8'h01);
        chk("rst_clkout", 8'(clk_out_o), 8'h00);
        @(negedge clk); rst = 0; m_on = 1;
        bus_read(8'd0, r); chk("mode_rst", r, 8'h01); chk("mode_model", r, m_mode);
        bus_read(8'd3, r); chk("ir_rst", r, 8'h00);
        bus_read(8'd1, r); chk("cmd_rd", r, 8'hFF);

        // T2 BTR0 protection
        bus_write(8'd6, 8'h05);
        bus_read(8'd6, r); chk("btr_rm", r, 8'h05);
        bus_write(8'd0, 8'h00);
        bus_write(8'd6, 8'h3F);
        bus_read(8'd6, r); chk("btr_prot", r, 8'h05); chk("btr_model", r, m_btr);

        // T5 bus-off (ahead of the transmit so tx_complete is still clear)
        bus_write(8'd0, 8'h01);
        bus_write(8'd14, 8'hFF);
        idle(2);
        chk("busoff_pin", 8'(bus_off_on), 8'h00);
        bus_read(8'd2, r); chk("status_bo", r, 8'h84);
        bus_read(8'd14, r); chk("txerr_model", r, m_txerr);
        bus_read(8'd3, r); chk("ir_bo", r, 8'h80);
        bus_write(8'd14, 8'h00);
        idle(2);
        chk("busoff_clr", 8'(bus_off_on), 8'h01);

        // T3 transmit
        bus_write(8'd6, 8'h00);
        bus_write(8'd10, 8'hA5);
        bus_write(8'd4, 8'h02);
        bus_write(8'd0, 8'h00);
        bus_write(8'd1, 8'h01);
        pat = 8'b1010_0101;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk($sformatf("tx_bit%0d", i), 8'(tx_o), 8'(pat[7 - i / 2]));
        end
        idle(3);
        chk("tx_irq", 8'(irq_on), 8'h00);
        chk("tx_idle", 8'(tx_o), 8'h01);
        bus_read(8'd2, r); chk("status_done", r, 8'h0C);
        bus_read(8'd4, r); chk("ier_model", r, m_ier);
        bus_read(8'd3, r); chk("ir_tx", r, 8'h02);
        idle(3);
        chk("irq_clr", 8'(irq_on), 8'h01);
        bus_read(8'd3, r); chk("ir_cleared", r, 8'h00);

        // T4 rx activity
        bus_write(8'd4, 8'h01);
        @(negedge clk); rx = 0;
        seen = 0; n = 0;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk); n = i;
            if (!irq_on) seen = 1;
        end
        chk("rx_irq_seen", 8'(seen), 8'h01);
        chk("rx_irq_lat", 8'(n <= 4), 8'h01);
        bus_read(8'd3, r); chk("ir_rx", r, 8'h01);
        rx = 1;
        idle(4);

        // T6 clock out
        bus_write(8'd31, 8'h01);
        wait_rise(t1, ok1);
        wait_rise(t2, ok2);
        chk("clk_rise", 8'(ok1 && ok2), 8'h01);
        chk("clk_period", 8'(t2 - t1), 8'h04);
        bus_write(8'd31, 8'h08);
        idle(1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (clk_out_o) seen = 1;
        end
        chk("clk_off", 8'(seen), 8'h00);
        bus_read(8'd31, r); chk("cdr_model", r, m_cdr);

        // T6 abort
        bus_write(8'd4, 8'h02);
        bus_write(8'd1, 8'h01);
        idle(5);
        bus_write(8'd0, 8'h01);
        #1;
        chk("abort_tx", 8'(tx_o), 8'h01);
        bus_read(8'd2, r); chk("abort_status", r, 8'h04);
        bus_read(8'd3, r); chk("abort_ir", r, 8'h00);
        chk("abort_irq", 8'(irq_on), 8'h01);
        idle(20);

        m_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
